// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and widths for the regfile write-port arbiter
package rf_arb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN_DEF   = 32;

    typedef enum logic {
        ARB_NORMAL   = 1'b0,
        ARB_FORCE_LL = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-destination scoreboard for long-latency results
// Decode stalls against the registered vector only; set beats clear on the same register.
module rf_scoreboard
    import rf_arb_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_is_long,
    input  logic                  ll_fire,
    input  logic [REG_ADDR_W-1:0] ll_rd,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  id_stall
);
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] pending_nxt;

    assign id_stall = id_valid & (pending[id_rs1] | pending[id_rs2] | pending[id_rd]);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (ll_fire) begin
            clr_vec[ll_rd] = 1'b1;
        end
        if (id_valid && id_is_long && !id_stall && id_rd != '0) begin
            set_vec[id_rd] = 1'b1;
        end
        pending_nxt    = (pending & ~clr_vec) | set_vec;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - regfile write-port arbiter between pipeline WB and the LL unit
// STARVE_GUARD_EN adds the starvation counter and the forced-LL-grant state.
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int NUM_REGS     = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  wb_hold,
    input  logic                  ll_valid,
    output logic                  ll_ready,
    input  logic [REG_ADDR_W-1:0] ll_rd,
    input  logic [XLEN-1:0]       ll_data,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_is_long,
    output logic                  id_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [NUM_REGS-1:0]   pending
);
    logic ll_fire;
    logic wb_fire;

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    assign ll_fire = ll_valid & ll_ready;
    assign wb_fire = wb_valid & ~wb_hold;

`ifdef STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [CNT_W-1:0]  starve_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_NORMAL;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (ll_valid && !ll_ready) begin
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wb_hold   = 1'b0;
        ll_ready  = ~wb_valid;
        case (state)
            ARB_NORMAL: begin
                if (ll_valid && wb_valid && starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                    state_nxt = ARB_FORCE_LL;
                end
            end
            ARB_FORCE_LL: begin
                wb_hold  = 1'b1;
                ll_ready = 1'b1;
                // ll_ready is 1 here, so either the result fires or ll_valid has dropped
                state_nxt = ARB_NORMAL;
            end
            default: state_nxt = ARB_NORMAL;
        endcase
    end
`else
    assign wb_hold  = 1'b0;
    assign ll_ready = ~wb_valid;
`endif

    // x0 writes are accepted from the requester but never enable the port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (wb_fire) begin
            rf_we    <= (wb_rd != '0);
            rf_waddr <= wb_rd;
            rf_wdata <= wb_data;
        end else if (ll_fire) begin
            rf_we    <= (ll_rd != '0);
            rf_waddr <= ll_rd;
            rf_wdata <= ll_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    rf_scoreboard #(
        .NUM_REGS(NUM_REGS)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_rd     (id_rd),
        .id_is_long(id_is_long),
        .ll_fire   (ll_fire),
        .ll_rd     (ll_rd),
        .pending   (pending),
        .id_stall  (id_stall)
    );
endmodule
